arcade_input_mapper: RTL and testbench

- Parametrised successor to the per-core keyboard/joystick glue in the arcade tops.
- Decodes hps_io ps2_key toggle events into latched key states through a parameter keymap.
- Merges those key states with per-player joystick bits into registered button vectors, in both polarities.
- Generates a fixed-width coin pulse per player from a designated button. Sits between hps_io and the game core.

---
 rtl/arcade_input_mapper.sv | 142 ++++++++++++++
 tb/tb_arcade_input_mapper.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_mapper.sv
// rtl/arcade_input_mapper.sv - PS/2 keymap latches, joystick merge and per-player coin pulse
module arcade_input_mapper #(
  parameter int NUM_PLAYERS    = 2,
  parameter int NUM_BUTTONS    = 3,
  parameter logic [9*NUM_PLAYERS*NUM_BUTTONS-1:0] KEYMAP = '0,
  parameter bit KEY_IGNORE_EXT = 1'b0,
  parameter int JOY_BASE       = 4,
  parameter int COIN_BTN       = 1,
  parameter int COIN_PULSE     = 8
) (
  input  logic                               i_clk_sys,
  input  logic                               i_reset,
  input  logic [10:0]                        i_ps2_key,
  input  logic                               i_key_clear,
  input  logic [16*NUM_PLAYERS-1:0]          i_joystick,
  output logic [NUM_PLAYERS*NUM_BUTTONS-1:0] o_btn,
  output logic [NUM_PLAYERS*NUM_BUTTONS-1:0] o_btn_n,
  output logic [NUM_PLAYERS-1:0]             o_coin_n
);

  localparam int NB = NUM_PLAYERS * NUM_BUTTONS;
  localparam int CW = $clog2(COIN_PULSE + 1);

  typedef enum logic {S_IDLE, S_PULSE} coin_state_t;

  logic              r_old_toggle;
  logic [NB-1:0]     r_latch;
  logic [NB-1:0]     r_btn;
  logic [NB-1:0]     r_btn_n;
  logic [NUM_PLAYERS-1:0] r_src_d;
  logic [NUM_PLAYERS-1:0] r_coin_n;
  coin_state_t       r_state [NUM_PLAYERS];
  logic [CW-1:0]     r_cnt   [NUM_PLAYERS];

  logic              w_event;
  logic [NB-1:0]     w_hit;
  logic [NB-1:0]     w_joy;
  logic [NB-1:0]     w_merged;
  logic [NUM_PLAYERS-1:0] w_src;
  logic              w_unused;

  assign w_event  = i_ps2_key[10] != r_old_toggle;
  assign w_merged = r_latch | w_joy;

  // Only the button slice of each joystick word is consumed; fold the rest away.
  assign w_unused = ^i_joystick;

  // Which keymap entries the current key code addresses (code 0 means unmapped).
  always_comb begin
    logic [8:0] v_code;
    v_code = '0;
    w_hit  = '0;
    for (int i = 0; i < NB; i++) begin
      v_code = KEYMAP[9*i +: 9];
      if (v_code != 9'h000) begin
        if (KEY_IGNORE_EXT)
          w_hit[i] = (v_code[7:0] == i_ps2_key[7:0]);
        else
          w_hit[i] = (v_code == i_ps2_key[8:0]);
      end
    end
  end

  // Pick each button's joystick bit out of its player's 16-bit word.
  always_comb begin
    w_joy = '0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      for (int b = 0; b < NUM_BUTTONS; b++)
        w_joy[p*NUM_BUTTONS+b] = i_joystick[16*p+JOY_BASE+b];
  end

  // Coin source per player is the registered designated button.
  always_comb begin
    w_src = '0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      w_src[p] = r_btn[p*NUM_BUTTONS+COIN_BTN];
  end

  // Toggle tracking and key latches; a clear request beats a same-cycle event.
  always_ff @(posedge i_clk_sys) begin
    r_old_toggle <= i_ps2_key[10];
    if (i_reset) begin
      r_latch <= '0;
    end else if (i_key_clear) begin
      r_latch <= '0;
    end else if (w_event) begin
      for (int i = 0; i < NB; i++)
        if (w_hit[i]) r_latch[i] <= i_ps2_key[9];
    end
  end

  // Registered merge of key latches and joystick bits, both polarities.
  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_btn   <= '0;
      r_btn_n <= '1;
    end else begin
      r_btn   <= w_merged;
      r_btn_n <= ~w_merged;
    end
  end

  // Per-player coin FSM: a rising source edge in IDLE yields a COIN_PULSE-wide low pulse.
  always_ff @(posedge i_clk_sys) begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (i_reset) begin
        r_src_d[p]  <= 1'b0;
        r_state[p]  <= S_IDLE;
        r_cnt[p]    <= '0;
        r_coin_n[p] <= 1'b1;
      end else begin
        r_src_d[p] <= w_src[p];
        case (r_state[p])
          S_IDLE: begin
            if (w_src[p] && !r_src_d[p]) begin
              r_state[p]  <= S_PULSE;
              r_coin_n[p] <= 1'b0;
              r_cnt[p]    <= CW'(COIN_PULSE - 1);
            end
          end
          S_PULSE: begin
            if (r_cnt[p] == '0) begin
              r_state[p]  <= S_IDLE;
              r_coin_n[p] <= 1'b1;
            end else begin
              r_cnt[p] <= r_cnt[p] - 1'b1;
            end
          end
          default: begin
            r_state[p]  <= S_IDLE;
            r_coin_n[p] <= 1'b1;
          end
        endcase
      end
    end
  end

  assign o_btn    = r_btn;
  assign o_btn_n  = r_btn_n;
  assign o_coin_n = r_coin_n;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb/tb_arcade_input_mapper.sv - scoreboard bench for arcade_input_mapper
module tb_arcade_input_mapper;

  localparam int NP = 2;
  localparam int NB = 3;
  // entries: 0=029, 1=unmapped, 2=06B, 3=01C, 4=01C (shared), 5=unmapped
  localparam logic [53:0] KM = {9'h000, 9'h01C, 9'h01C, 9'h06B, 9'h000, 9'h029};

  logic              clk = 1'b0;
  logic              reset;
  logic [10:0]       ps2_key;
  logic              key_clear;
  logic [31:0]       joystick;
  logic [5:0]        a_btn, a_btn_n, b_btn, b_btn_n;
  logic [1:0]        a_coin_n, b_coin_n;

  int                cyc = 0;
  int                n_total = 0;
  int                n_bad = 0;
  logic              tog;

  typedef struct {
    int   cyc;
    int   sel;
    int   idx;
    logic val;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  arcade_input_mapper #(
    .NUM_PLAYERS(NP), .NUM_BUTTONS(NB), .KEYMAP(KM), .KEY_IGNORE_EXT(1'b0),
    .JOY_BASE(4), .COIN_BTN(1), .COIN_PULSE(3)
  ) dut_a (
    .i_clk_sys(clk), .i_reset(reset), .i_ps2_key(ps2_key), .i_key_clear(key_clear),
    .i_joystick(joystick), .o_btn(a_btn), .o_btn_n(a_btn_n), .o_coin_n(a_coin_n)
  );

  arcade_input_mapper #(
    .NUM_PLAYERS(NP), .NUM_BUTTONS(NB), .KEYMAP(KM), .KEY_IGNORE_EXT(1'b1),
    .JOY_BASE(4), .COIN_BTN(1), .COIN_PULSE(3)
  ) dut_b (
    .i_clk_sys(clk), .i_reset(reset), .i_ps2_key(ps2_key), .i_key_clear(key_clear),
    .i_joystick(joystick), .o_btn(b_btn), .o_btn_n(b_btn_n), .o_coin_n(b_coin_n)
  );

  function automatic logic get_bit(int sel, int idx);
    case (sel)
      0:       return a_btn[idx];
      1:       return a_btn_n[idx];
      2:       return a_coin_n[idx];
      default: return b_btn[idx];
    endcase
  endfunction

  function automatic string sel_name(int sel);
    case (sel)
      0:       return "a_btn";
      1:       return "a_btn_n";
      2:       return "a_coin_n";
      default: return "b_btn";
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        n_total++;
        if (q[i].cyc < cyc) begin
          n_bad++;
          $display("FAIL %s[%0d] missed check due cyc=%0d now=%0d", sel_name(q[i].sel),
                   q[i].idx, q[i].cyc, cyc);
        end else if (get_bit(q[i].sel, q[i].idx) !== q[i].val) begin
          n_bad++;
          $display("FAIL %s[%0d] cyc=%0d got=%0b want=%0b", sel_name(q[i].sel), q[i].idx,
                   cyc, get_bit(q[i].sel, q[i].idx), q[i].val);
        end
        q.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(int n);
    while (cyc < n) step();
  endtask

  task automatic expect_at(int dc, int sel, int idx, logic val);
    exp_t e;
    e.cyc = cyc + dc;
    e.sel = sel;
    e.idx = idx;
    e.val = val;
    q.push_back(e);
  endtask

  task automatic key_event(logic pressed, logic [8:0] code);
    tog = ~tog;
    ps2_key = {tog, pressed, code};
  endtask

  initial begin
    reset     = 1'b1;
    key_clear = 1'b0;
    joystick  = '0;
    tog       = 1'b1;
    ps2_key   = {1'b1, 1'b1, 9'h029};   // stale toggle present across reset

    step();                              // cyc 1: reset has been sampled
    expect_at(0, 0, 0, 1'b0);
    expect_at(0, 1, 0, 1'b1);
    expect_at(0, 1, 5, 1'b1);
    expect_at(0, 2, 0, 1'b1);
    expect_at(0, 2, 1, 1'b1);
    step();                              // cyc 2
    reset = 1'b0;
    expect_at(2, 0, 0, 1'b0);            // stale toggle must not latch
    expect_at(4, 0, 0, 1'b0);

    // press/release entry 0
    wait_cyc(10);
    key_event(1'b1, 9'h029);
    expect_at(1, 0, 0, 1'b0);
    expect_at(2, 0, 0, 1'b1);
    expect_at(2, 1, 0, 1'b0);
    wait_cyc(14);
    key_event(1'b0, 9'h029);
    expect_at(1, 0, 0, 1'b1);
    expect_at(2, 0, 0, 1'b0);
    expect_at(2, 1, 0, 1'b1);

    // extended bit: 16B vs mapped 06B
    wait_cyc(18);
    key_event(1'b1, 9'h16B);
    expect_at(2, 0, 2, 1'b0);
    expect_at(2, 3, 2, 1'b1);
    wait_cyc(22);
    key_event(1'b0, 9'h16B);
    expect_at(2, 3, 2, 1'b0);
    wait_cyc(26);
    key_event(1'b1, 9'h06B);
    expect_at(2, 0, 2, 1'b1);
    wait_cyc(30);
    key_event(1'b0, 9'h06B);
    expect_at(2, 0, 2, 1'b0);

    // merge: player 1 button 0 via joystick and shared key code
    wait_cyc(34);
    joystick[20] = 1'b1;
    expect_at(0, 0, 3, 1'b0);
    expect_at(1, 0, 3, 1'b1);
    expect_at(1, 0, 4, 1'b0);
    wait_cyc(36);
    key_event(1'b1, 9'h01C);
    expect_at(2, 0, 3, 1'b1);
    expect_at(2, 0, 4, 1'b1);
    wait_cyc(40);
    joystick[20] = 1'b0;
    expect_at(1, 0, 3, 1'b1);
    expect_at(2, 0, 3, 1'b1);
    wait_cyc(44);
    key_event(1'b0, 9'h01C);
    expect_at(2, 0, 3, 1'b0);
    expect_at(2, 0, 4, 1'b0);

    // key_clear wins over a same-cycle press, then clears a held latch
    wait_cyc(50);
    key_event(1'b1, 9'h029);
    key_clear = 1'b1;
    expect_at(2, 0, 0, 1'b0);
    expect_at(3, 0, 0, 1'b0);
    step();
    key_clear = 1'b0;
    wait_cyc(54);
    key_event(1'b1, 9'h029);
    expect_at(2, 0, 0, 1'b1);
    wait_cyc(58);
    key_clear = 1'b1;
    expect_at(1, 0, 0, 1'b1);
    expect_at(2, 0, 0, 1'b0);
    step();
    key_clear = 1'b0;

    // coin: hold player-0 button 1 for 20 cycles
    wait_cyc(64);
    joystick[5] = 1'b1;
    expect_at(1, 0, 1, 1'b1);
    expect_at(1, 2, 0, 1'b1);
    expect_at(2, 2, 0, 1'b0);
    expect_at(3, 2, 0, 1'b0);
    expect_at(3, 2, 1, 1'b1);
    expect_at(4, 2, 0, 1'b0);
    for (int k = 5; k <= 23; k++) expect_at(k, 2, 0, 1'b1);
    wait_cyc(84);
    joystick[5] = 1'b0;
    expect_at(1, 0, 1, 1'b0);
    wait_cyc(86);
    joystick[5] = 1'b1;                  // re-press 2 cycles after release
    expect_at(2, 2, 0, 1'b0);
    expect_at(3, 2, 0, 1'b0);
    expect_at(4, 2, 0, 1'b0);
    expect_at(5, 2, 0, 1'b1);
    wait_cyc(94);
    joystick[5] = 1'b0;

    // reset mid-pulse with source held
    wait_cyc(100);
    joystick[5] = 1'b1;
    expect_at(2, 2, 0, 1'b0);
    expect_at(3, 2, 0, 1'b0);
    wait_cyc(103);
    reset = 1'b1;
    expect_at(1, 2, 0, 1'b1);
    expect_at(1, 0, 1, 1'b0);
    step();                              // cyc 104
    reset = 1'b0;
    expect_at(1, 0, 1, 1'b1);
    expect_at(1, 2, 0, 1'b1);
    expect_at(2, 2, 0, 1'b0);
    expect_at(3, 2, 0, 1'b0);
    expect_at(4, 2, 0, 1'b0);
    expect_at(5, 2, 0, 1'b1);
    expect_at(8, 2, 0, 1'b1);

    // drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 50 && q.size() > 0; k++) step();
    step();
    n_total++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
